cm_notify_tx: RTL and testbench

- Transmit-side companion of the CM configuration module.
- Accepts one-cycle event strobes from CM:
  - configuration notifications
  - configuration errors
  - VGA notifications
- Latches each event in a per-source pending slot, arbitrates between sources and serialises each event into a two-byte frame (header + payload).
- Pushes the frame bytes into the UART TX FIFO. This is the reverse path of the RX-FIFO byte stream that CM consumes.

---
 rtl/cm_notify_tx_pkg.sv | 23 ++
 rtl/cm_notify_tx_if.sv | 11 +
 rtl/cm_event_latch.sv | 49 ++++
 rtl/cm_notify_tx.sv | 121 ++++++++++++
 tb/tb_cm_notify_tx.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/cm_notify_tx_pkg.sv
// Shared widths, frame TYPE codes and FSM encodings for the CM notification
// transmitter.
package cm_notify_tx_pkg;

  localparam int UART_DATA_WIDTH           = 8;
  localparam int CONFIG_NOTIFICATION_WIDTH = 4;
  localparam int CONFIG_ERROR_WIDTH        = 4;
  localparam int VGA_NOTIFICATION_WIDTH    = 4;
  localparam int SEQ_WIDTH                 = 6;

  typedef enum logic [1:0] {
    TYPE_CFG = 2'b01,
    TYPE_ERR = 2'b10,
    TYPE_VGA = 2'b11
  } frame_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/cm_notify_tx_if.sv
// Byte-push link between the notification transmitter and the UART TX FIFO.
interface cm_notify_tx_if #(
    parameter int DW = 8
);
    logic          Full;
    logic [DW-1:0] TXD_Data;
    logic          Write_En;

    modport master (input Full, output TXD_Data, output Write_En);
    modport slave  (output Full, input TXD_Data, input Write_En);
endinterface

// File: rtl/cm_event_latch.sv
// One pending slot: holds an event code until the arbiter consumes it and
// flags events that arrive while the slot is already occupied.
module cm_event_latch #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic [W-1:0] code_in,
    input  logic         consume,
    output logic         flag,
    output logic [W-1:0] code,
    output logic         overflow
);
    logic         flag_q, flag_d;
    logic [W-1:0] code_q, code_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        flag_d = flag_q & ~consume;
        code_d = code_q;
        ovf_d  = 1'b0;
        // A slot being drained this cycle has room for the incoming event.
        if (valid) begin
            if (!flag_q || consume) begin
                flag_d = 1'b1;
                code_d = code_in;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
            code_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            code_q <= code_d;
            ovf_q  <= ovf_d;
        end
    end

    assign flag     = flag_q;
    assign code     = code_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/cm_notify_tx.sv
// Arbitrates CM error/config/VGA events and serialises each into a
// header+payload byte pair pushed into the UART TX FIFO.
module cm_notify_tx
  import cm_notify_tx_pkg::*;
#(
    parameter int UART_DATA_WIDTH           = cm_notify_tx_pkg::UART_DATA_WIDTH,
    parameter int CONFIG_NOTIFICATION_WIDTH = cm_notify_tx_pkg::CONFIG_NOTIFICATION_WIDTH,
    parameter int CONFIG_ERROR_WIDTH        = cm_notify_tx_pkg::CONFIG_ERROR_WIDTH,
    parameter int VGA_NOTIFICATION_WIDTH    = cm_notify_tx_pkg::VGA_NOTIFICATION_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
    input  logic                                 Config_Notification_Valid,
    input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
    input  logic                                 Error_Valid,
    input  logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
    input  logic                                 VGA_Notification_Valid,
    cm_notify_tx_if.master                       fifo,
    output logic                                 Overflow,
    output logic                                 Busy
);
    logic                                 err_flag, cfg_flag, vga_flag;
    logic [CONFIG_ERROR_WIDTH-1:0]        err_code;
    logic [CONFIG_NOTIFICATION_WIDTH-1:0] cfg_code;
    logic [VGA_NOTIFICATION_WIDTH-1:0]    vga_code;
    logic                                 err_ovf, cfg_ovf, vga_ovf;
    logic                                 err_cons, cfg_cons, vga_cons;

    cm_event_latch #(.W(CONFIG_ERROR_WIDTH)) u_err (
        .clk(clk), .rst_n(rst_n), .valid(Error_Valid), .code_in(Config_Error),
        .consume(err_cons), .flag(err_flag), .code(err_code), .overflow(err_ovf));
    cm_event_latch #(.W(CONFIG_NOTIFICATION_WIDTH)) u_cfg (
        .clk(clk), .rst_n(rst_n), .valid(Config_Notification_Valid),
        .code_in(Config_Notification), .consume(cfg_cons), .flag(cfg_flag),
        .code(cfg_code), .overflow(cfg_ovf));
    cm_event_latch #(.W(VGA_NOTIFICATION_WIDTH)) u_vga (
        .clk(clk), .rst_n(rst_n), .valid(VGA_Notification_Valid),
        .code_in(VGA_Notification), .consume(vga_cons), .flag(vga_flag),
        .code(vga_code), .overflow(vga_ovf));

    tx_state_e                  state_q, state_d;
    logic [SEQ_WIDTH-1:0]       seq_q, seq_d;
    logic [UART_DATA_WIDTH-1:0] txd_q, txd_d;
    logic [UART_DATA_WIDTH-1:0] fcode_q, fcode_d;
    logic                       busy_q, busy_d;
    frame_type_e                win_type;
    logic [UART_DATA_WIDTH-1:0] win_code;

    // Fixed priority: error, then config notification, then VGA.
    always_comb begin
        win_type = TYPE_VGA;
        win_code = UART_DATA_WIDTH'(vga_code);
        if (err_flag) begin
            win_type = TYPE_ERR;
            win_code = UART_DATA_WIDTH'(err_code);
        end else if (cfg_flag) begin
            win_type = TYPE_CFG;
            win_code = UART_DATA_WIDTH'(cfg_code);
        end
    end

    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        txd_d         = txd_q;
        fcode_d       = fcode_q;
        err_cons      = 1'b0;
        cfg_cons      = 1'b0;
        vga_cons      = 1'b0;
        fifo.Write_En = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (err_flag || cfg_flag || vga_flag) begin
                    err_cons = err_flag;
                    cfg_cons = !err_flag && cfg_flag;
                    vga_cons = !err_flag && !cfg_flag;
                    txd_d    = {win_type, seq_q};
                    fcode_d  = win_code;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!fifo.Full) begin
                    fifo.Write_En = 1'b1;
                    txd_d         = fcode_q;
                    state_d       = ST_PAY;
                end
            end
            ST_PAY: begin
                if (!fifo.Full) begin
                    fifo.Write_En = 1'b1;
                    seq_d         = seq_q + 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_q != ST_IDLE) || err_flag || cfg_flag || vga_flag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            txd_q   <= '0;
            fcode_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            txd_q   <= txd_d;
            fcode_q <= fcode_d;
            busy_q  <= busy_d;
        end
    end

    assign fifo.TXD_Data = txd_q;
    assign Overflow      = err_ovf | cfg_ovf | vga_ovf;
    assign Busy          = busy_q;
endmodule

// File: tb/tb_cm_notify_tx.sv
// Directed bench for cm_notify_tx: single/simultaneous frames, backpressure,
// overflow, SEQ wrap and reset mid-frame.
module tb_cm_notify_tx;
    logic       clk;
    logic       rst_n;
    logic [3:0] cfg_code, err_code, vga_code;
    logic       cfg_v, err_v, vga_v;
    logic       ovf, busy;
    logic [5:0] seq;
    int         checks;
    int         failures;

    cm_notify_tx_if fif ();

    cm_notify_tx dut (
        .clk(clk), .rst_n(rst_n),
        .Config_Notification(cfg_code), .Config_Notification_Valid(cfg_v),
        .Config_Error(err_code), .Error_Valid(err_v),
        .VGA_Notification(vga_code), .VGA_Notification_Valid(vga_v),
        .fifo(fif), .Overflow(ovf), .Busy(busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] b);
        cyc();
        #1;
        chk1({tag, "_we"}, fif.Write_En, 1'b1);
        chk8(tag, fif.TXD_Data, b);
    endtask

    task automatic nopush(input string tag);
        cyc();
        #1;
        chk1(tag, fif.Write_En, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0; seq = '0;
        rst_n = 1'b1; fif.Full = 1'b0;
        cfg_v = 0; err_v = 0; vga_v = 0;
        cfg_code = '0; err_code = '0; vga_code = '0;
        #2 rst_n = 1'b0;
        #1;
        chk8("rst_txd", fif.TXD_Data, 8'h00);
        chk1("rst_we", fif.Write_En, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        cyc(); cyc();
        rst_n = 1'b1;

        // single error event, code 3
        cyc(); err_v = 1; err_code = 4'h3;
        cyc(); err_v = 0;
        push("t1_hdr", 8'h80);
        push("t1_pay", 8'h03);
        nopush("t1_idle");
        chk1("t1_busy_tail", busy, 1'b1);
        cyc(); chk1("t1_busy_low", busy, 1'b0);

        // simultaneous strobes from a fresh SEQ
        do_reset();
        cyc(); err_v = 1; err_code = 4'h2; cfg_v = 1; cfg_code = 4'h1; vga_v = 1; vga_code = 4'h3;
        cyc(); err_v = 0; cfg_v = 0; vga_v = 0;
        push("t2_err_hdr", 8'h80); push("t2_err_pay", 8'h02); nopush("t2_gap0");
        push("t2_cfg_hdr", 8'h41); push("t2_cfg_pay", 8'h01); nopush("t2_gap1");
        push("t2_vga_hdr", 8'hC2); push("t2_vga_pay", 8'h03); nopush("t2_done");
        seq = 6'd3;

        // backpressure on the header for 5 cycles
        cyc(); cfg_v = 1; cfg_code = 4'h5;
        cyc(); cfg_v = 0;
        cyc(); fif.Full = 1'b1; #1;
        chk1("t3_stall_we", fif.Write_En, 1'b0);
        chk8("t3_stall_txd", fif.TXD_Data, {2'b01, seq});
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk1("t3_stall_we", fif.Write_En, 1'b0);
            chk8("t3_stall_txd", fif.TXD_Data, {2'b01, seq});
        end
        cyc(); fif.Full = 1'b0; #1;
        chk1("t3_hdr_we", fif.Write_En, 1'b1);
        chk8("t3_hdr", fif.TXD_Data, {2'b01, seq});
        push("t3_pay", 8'h05);
        seq = seq + 6'd1;
        nopush("t3_once");

        // overflow: second VGA strobe while the first is still pending
        cyc(); fif.Full = 1'b1; cfg_v = 1; cfg_code = 4'h9;
        cyc(); cfg_v = 0;
        cyc(); vga_v = 1; vga_code = 4'h6; #1;
        chk1("t4_ovf_a", ovf, 1'b0);
        cyc(); vga_v = 0;
        chk1("t4_ovf_b", ovf, 1'b0);
        cyc(); vga_v = 1; vga_code = 4'h7;
        chk1("t4_ovf_c", ovf, 1'b0);
        cyc(); vga_v = 0;
        chk1("t4_ovf_pulse", ovf, 1'b1);
        cyc();
        chk1("t4_ovf_clear", ovf, 1'b0);
        fif.Full = 1'b0; #1;
        chk1("t4_cfg_hdr_we", fif.Write_En, 1'b1);
        chk8("t4_cfg_hdr", fif.TXD_Data, {2'b01, seq});
        push("t4_cfg_pay", 8'h09);
        seq = seq + 6'd1;
        nopush("t4_gap");
        push("t4_vga_hdr", {2'b11, seq});
        push("t4_vga_pay", 8'h06);
        nopush("t4_no_second0");
        nopush("t4_no_second1");
        nopush("t4_no_second2");

        // SEQ wrap over 65 config frames
        do_reset();
        for (int i = 0; i < 65; i++) begin
            cyc(); cfg_v = 1; cfg_code = 4'(i);
            cyc(); cfg_v = 0;
            push("t5_hdr", 8'h40 + 8'(i % 64));
            push("t5_pay", 8'(i % 16));
        end
        seq = 6'd1;

        // reset asserted during the payload cycle
        cyc(); err_v = 1; err_code = 4'hA;
        cyc(); err_v = 0;
        push("t6_hdr", {2'b10, seq});
        cyc();
        chk8("t6_pay_pre", fif.TXD_Data, 8'h0A);
        rst_n = 1'b0; #1;
        chk8("t6_rst_txd", fif.TXD_Data, 8'h00);
        chk1("t6_rst_we", fif.Write_En, 1'b0);
        chk1("t6_rst_ovf", ovf, 1'b0);
        chk1("t6_rst_busy", busy, 1'b0);
        cyc(); rst_n = 1'b1;
        cyc(); err_v = 1; err_code = 4'h4;
        cyc(); err_v = 0;
        push("t6_new_hdr", 8'h80);
        push("t6_new_pay", 8'h04);
        nopush("t6_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
